// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter (clear > load > count); one step per enabled edge, no backpressure.
// Define BCD_COUNTER_SATURATE_EN to hold at all-9s/all-0s instead of wrapping.
module bcd_updown_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done,
  output logic                  wrapped
);

  logic [DIGITS-1:0]   term;
  logic [DIGITS-1:0]   step_en;
  logic                carry;
  logic                all_term;
  logic [4*DIGITS-1:0] stepped;
  logic [4*DIGITS-1:0] clamped;

  always_comb begin
    term    = '0;
    step_en = '0;
    carry   = enable;
    stepped = count;
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      term[i]    = up ? (count[4*i +: 4] == 4'd9) : (count[4*i +: 4] == 4'd0);
      step_en[i] = carry;
      carry      = carry & term[i];
      // Illegal codes 10..15 resolve to 0 going up and to 9 going down.
      if (step_en[i]) begin
        if (up)
          stepped[4*i +: 4] = (count[4*i +: 4] >= 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
        else
          stepped[4*i +: 4] = (count[4*i +: 4] == 4'd0 || count[4*i +: 4] > 4'd9) ?
                              4'd9 : count[4*i +: 4] - 4'd1;
      end
      clamped[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
    all_term = &term;
  end

  assign done = enable & ~clear & ~load & all_term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= clamped;
      wrapped <= 1'b0;
    end else if (enable) begin
`ifdef BCD_COUNTER_SATURATE_EN
      if (all_term)
        wrapped <= 1'b1;
      else
        count <= stepped;
`else
      count <= stepped;
      if (all_term)
        wrapped <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=3): stimulus queues expected state, monitor compares on negedge.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        up = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_value = '0;
  logic        clear = 1'b0;
  logic [11:0] count;
  logic        done;
  logic        wrapped;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  typedef struct {
    logic [11:0] cnt;
    logic        dn;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];

  bcd_updown_counter #(.DIGITS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear),
    .count(count), .done(done), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

  // Drive one cycle of inputs just after the edge and queue what the monitor should see before the next edge.
  task automatic cyc(input logic rs, input logic en, input logic u, input logic ld,
                     input logic [11:0] lv, input logic cl,
                     input logic [11:0] ecnt, input logic edn, input logic ewr);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; enable = en; up = u; load = ld; load_value = lv; clear = cl;
    e.cnt = ecnt; e.dn = edn; e.wr = ewr;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (count !== e.cnt) begin
          failures++;
          $display("FAIL count @%0d: got %h expected %h", cycle_no, count, e.cnt);
        end
        if (done !== e.dn) begin
          failures++;
          $display("FAIL done @%0d: got %b expected %b (count %h)", cycle_no, done, e.dn, count);
        end
        if (wrapped !== e.wr) begin
          failures++;
          $display("FAIL wrapped @%0d: got %b expected %b (count %h)", cycle_no, wrapped, e.wr, count);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int waited;
    // Reset state.
    cyc(1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0);
`ifdef BCD_COUNTER_SATURATE_EN
    cyc(0, 0, 1, 1, 12'h997, 0, 12'h000, 0, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h997, 0, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h998, 0, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h999, 1, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h999, 1, 1);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h999, 1, 1);
    cyc(0, 0, 0, 1, 12'h001, 0, 12'h999, 0, 1);
    cyc(0, 1, 0, 0, 12'h000, 0, 12'h001, 0, 0);
    cyc(0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 0);
    cyc(0, 1, 0, 0, 12'h000, 0, 12'h000, 1, 1);
    cyc(0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 1);
`else
    // Full up-count 000..999 -> 000.
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h000, 0, 0);
    for (int i = 1; i <= 1000; i++)
      cyc(0, 1, 1, 0, 12'h000, 0, bcd(i % 1000), (i == 999), (i >= 1000));
    // Clamped load, then one up step.
    cyc(0, 1, 1, 1, 12'h1F9, 0, 12'h001, 0, 1);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h199, 0, 0);
    cyc(0, 0, 1, 0, 12'h000, 0, 12'h200, 0, 0);
    // Down from 100 through 000 and wrap to 999.
    cyc(0, 0, 0, 1, 12'h100, 0, 12'h200, 0, 0);
    cyc(0, 1, 0, 0, 12'h000, 0, 12'h100, 0, 0);
    for (int k = 99; k >= 0; k--)
      cyc(0, 1, 0, 0, 12'h000, 0, bcd(k), (k == 0), 0);
    // Clear beats load and count at 999.
    cyc(0, 1, 1, 1, 12'h555, 1, 12'h999, 0, 1);
    cyc(0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0);
    // Direction change mid-count.
    cyc(0, 0, 1, 1, 12'h050, 0, 12'h000, 0, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h050, 0, 0);
    cyc(0, 1, 0, 0, 12'h000, 0, 12'h051, 0, 0);
    cyc(0, 0, 0, 0, 12'h000, 0, 12'h050, 0, 0);
    // Async reset at 437; first edge after release with enable high -> 001.
    cyc(0, 0, 1, 1, 12'h437, 0, 12'h050, 0, 0);
    cyc(0, 0, 1, 0, 12'h000, 0, 12'h437, 0, 0);
    cyc(1, 1, 1, 0, 12'h000, 0, 12'h000, 0, 0);
    cyc(0, 1, 1, 0, 12'h000, 0, 12'h000, 0, 0);
    cyc(0, 0, 1, 0, 12'h000, 0, 12'h001, 0, 0);
`endif
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
